dfe_isi_canceller: RTL and testbench



---
 rtl/serdes_rx_pkg.sv | 38 +++
 rtl/dfe_isi_canceller_if.sv | 25 ++
 rtl/dfe_tap_mac.sv | 30 +++
 rtl/dfe_isi_canceller.sv | 151 +++++++++++++++
 tb/tb_dfe_isi_canceller.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/serdes_rx_pkg.sv
// Shared SerDes receive definitions: PAM4 level constants, Gray symbol map and
// the DFE canceller FSM state type.
package serdes_rx_pkg;

    localparam int DEF_SYMBOL_SEPERATION = 56;
    localparam int LVL_NEG_OUTER = -3 * DEF_SYMBOL_SEPERATION / 2;
    localparam int LVL_NEG_INNER = -DEF_SYMBOL_SEPERATION / 2;
    localparam int LVL_POS_INNER = DEF_SYMBOL_SEPERATION / 2;
    localparam int LVL_POS_OUTER = 3 * DEF_SYMBOL_SEPERATION / 2;

    localparam logic [1:0] GRAY_NEG_OUTER = 2'b00;
    localparam logic [1:0] GRAY_NEG_INNER = 2'b01;
    localparam logic [1:0] GRAY_POS_INNER = 2'b11;
    localparam logic [1:0] GRAY_POS_OUTER = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        WAIT_DEC,
        UPDATE
    } dfe_state_e;

    // Zero and any off-grid value fall back to the -S/2 code.
    function automatic logic [1:0] gray_map(input logic signed [31:0] value, input int sep);
        logic [1:0] code;
        code = GRAY_NEG_INNER;
        if (value == -3 * sep / 2)
            code = GRAY_NEG_OUTER;
        else if (value == -sep / 2)
            code = GRAY_NEG_INNER;
        else if (value == sep / 2)
            code = GRAY_POS_INNER;
        else if (value == 3 * sep / 2)
            code = GRAY_POS_OUTER;
        return code;
    endfunction

endpackage

// File: rtl/dfe_isi_canceller_if.sv
// Sample / estimation / decision handshake bundle between the DFE canceller
// and its neighbours.
interface dfe_isi_canceller_if #(
    parameter int W = 16
);
    logic signed [W-1:0] sample;
    logic                s_valid;
    logic                s_ready;
    logic signed [W-1:0] estimation;
    logic                e_valid;
    logic signed [W-1:0] feedback_value;
    logic                f_valid;
    logic [1:0]          sym_out;
    logic                sym_valid;

    modport master (
        output sample, s_valid, feedback_value, f_valid,
        input  s_ready, estimation, e_valid, sym_out, sym_valid
    );

    modport slave (
        input  sample, s_valid, feedback_value, f_valid,
        output s_ready, estimation, e_valid, sym_out, sym_valid
    );
endinterface

// File: rtl/dfe_tap_mac.sv
// Combinational feedback multiply-accumulate: sum of tap[k]*hist[k] at full
// precision, scaled back from Q1.(R-1) by an arithmetic shift.
module dfe_tap_mac #(
    parameter int NUM_TAPS          = 2,
    parameter int SIGNAL_RESOLUTION = 8,
    parameter int W                 = 16,
    parameter int ACC_W             = SIGNAL_RESOLUTION + W + $clog2(NUM_TAPS) + 1
) (
    input  logic [NUM_TAPS*SIGNAL_RESOLUTION-1:0] taps,
    input  logic [NUM_TAPS*W-1:0]                 hist,
    output logic signed [ACC_W-1:0]               isi
);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] tap_ext;
    logic signed [ACC_W-1:0] hist_ext;

    always_comb begin
        acc      = '0;
        tap_ext  = '0;
        hist_ext = '0;
        for (int unsigned k = 0; k < NUM_TAPS; k++) begin
            tap_ext  = ACC_W'($signed(taps[k*SIGNAL_RESOLUTION +: SIGNAL_RESOLUTION]));
            hist_ext = ACC_W'($signed(hist[k*W +: W]));
            acc      = acc + tap_ext * hist_ext;
        end
        isi = acc >>> (SIGNAL_RESOLUTION - 1);
    end

endmodule

// File: rtl/dfe_isi_canceller.sv
// Decision-feedback ISI canceller: subtracts the tap-weighted decision history
// from each sample and waits for the slicer decision to extend the history.
module dfe_isi_canceller
    import serdes_rx_pkg::*;
#(
    parameter int PULSE_RESPONSE_LENGTH = 2,
    parameter int SIGNAL_RESOLUTION     = 8,
    parameter int SYMBOL_SEPERATION     = 56,
    parameter int NUM_TAPS              = 2,
    parameter int TIMEOUT               = 15,
    localparam int AW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
) (
    input  logic                                clk,
    input  logic                                rstn,
    dfe_isi_canceller_if.slave                  bus,
    input  logic                                tap_we,
    input  logic [AW-1:0]                       tap_addr,
    input  logic signed [SIGNAL_RESOLUTION-1:0] tap_wdata,
    output logic                                dec_timeout
);

    localparam int R     = SIGNAL_RESOLUTION;
    localparam int W     = SIGNAL_RESOLUTION * PULSE_RESPONSE_LENGTH;
    localparam int ACC_W = R + W + $clog2(NUM_TAPS) + 1;
    localparam int DW    = ACC_W + 1;
    localparam int CW    = $clog2(TIMEOUT + 1);

    localparam logic signed [W-1:0]  W_MAX  = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]  W_MIN  = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [DW-1:0] EST_MAX = DW'(W_MAX);
    localparam logic signed [DW-1:0] EST_MIN = DW'(W_MIN);

    dfe_state_e              state;
    logic signed [R-1:0]     taps [NUM_TAPS];
    logic signed [W-1:0]     hist [NUM_TAPS];
    logic signed [W-1:0]     sample_q;
    logic signed [W-1:0]     fb_q;
    logic [CW-1:0]           wait_cnt;

    logic [NUM_TAPS*R-1:0]   taps_flat;
    logic [NUM_TAPS*W-1:0]   hist_flat;
    logic signed [ACC_W-1:0] isi;
    logic signed [DW-1:0]    diff;
    logic signed [W-1:0]     est_sat;
    logic                    addr_ok;

    always_comb begin
        taps_flat = '0;
        hist_flat = '0;
        for (int unsigned k = 0; k < NUM_TAPS; k++) begin
            taps_flat[k*R +: R] = taps[k];
            hist_flat[k*W +: W] = hist[k];
        end
    end

    dfe_tap_mac #(
        .NUM_TAPS          (NUM_TAPS),
        .SIGNAL_RESOLUTION (R),
        .W                 (W),
        .ACC_W             (ACC_W)
    ) u_mac (
        .taps (taps_flat),
        .hist (hist_flat),
        .isi  (isi)
    );

    always_comb begin
        diff = DW'(sample_q) - DW'(isi);
        if (diff > EST_MAX)
            est_sat = W_MAX;
        else if (diff < EST_MIN)
            est_sat = W_MIN;
        else
            est_sat = diff[W-1:0];
    end

    assign addr_ok = ({1'b0, tap_addr} < (AW+1)'(NUM_TAPS));

    // Taps update independently of the FSM; a write landing on the CALC edge
    // is seen only by the following sample.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned k = 0; k < NUM_TAPS; k++)
                taps[k] <= '0;
        end else if (tap_we && addr_ok) begin
            taps[tap_addr] <= tap_wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            sample_q       <= '0;
            fb_q           <= '0;
            wait_cnt       <= '0;
            for (int unsigned k = 0; k < NUM_TAPS; k++)
                hist[k] <= '0;
            bus.s_ready    <= 1'b0;
            bus.estimation <= '0;
            bus.e_valid    <= 1'b0;
            bus.sym_out    <= '0;
            bus.sym_valid  <= 1'b0;
            dec_timeout    <= 1'b0;
        end else begin
            bus.e_valid   <= 1'b0;
            bus.sym_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.s_valid && bus.s_ready) begin
                        sample_q    <= bus.sample;
                        bus.s_ready <= 1'b0;
                        state       <= CALC;
                    end else begin
                        bus.s_ready <= 1'b1;
                    end
                end
                CALC: begin
                    bus.estimation <= est_sat;
                    bus.e_valid    <= 1'b1;
                    wait_cnt       <= '0;
                    state          <= WAIT_DEC;
                end
                WAIT_DEC: begin
                    // Cycle 0 is the e_valid cycle; the slicer cannot answer yet.
                    wait_cnt <= wait_cnt + CW'(1);
                    if (wait_cnt != '0 && bus.f_valid) begin
                        fb_q          <= bus.feedback_value;
                        bus.sym_out   <= gray_map(32'(bus.feedback_value), SYMBOL_SEPERATION);
                        bus.sym_valid <= 1'b1;
                        state         <= UPDATE;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        fb_q          <= '0;
                        bus.sym_out   <= gray_map('0, SYMBOL_SEPERATION);
                        bus.sym_valid <= 1'b1;
                        dec_timeout   <= 1'b1;
                        state         <= UPDATE;
                    end
                end
                UPDATE: begin
                    hist[0] <= fb_q;
                    for (int unsigned k = 1; k < NUM_TAPS; k++)
                        hist[k] <= hist[k-1];
                    bus.s_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dfe_isi_canceller.sv
// Directed + randomized bench for dfe_isi_canceller against an arithmetic
// reference of the canceller, decision timing and Gray map.
module tb_dfe_isi_canceller;

    localparam int S       = 56;
    localparam int TIMEOUT = 15;
    localparam int W       = 16;

    logic              clk;
    logic              rstn;
    logic              tap_we;
    logic [0:0]        tap_addr;
    logic signed [7:0] tap_wdata;
    logic              dec_timeout;

    dfe_isi_canceller_if #(.W(W)) bus ();

    dfe_isi_canceller #(
        .PULSE_RESPONSE_LENGTH (2),
        .SIGNAL_RESOLUTION     (8),
        .SYMBOL_SEPERATION     (S),
        .NUM_TAPS              (2),
        .TIMEOUT               (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .bus         (bus),
        .tap_we      (tap_we),
        .tap_addr    (tap_addr),
        .tap_wdata   (tap_wdata),
        .dec_timeout (dec_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int m_tap [2];
    int m_hist [2];
    bit m_to;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_est(input int smp);
        int isi;
        int d;
        isi = 0;
        for (int k = 0; k < 2; k++)
            isi += m_tap[k] * m_hist[k];
        isi = isi >>> 7;
        d = smp - isi;
        if (d > 32767) d = 32767;
        if (d < -32768) d = -32768;
        return d;
    endfunction

    function automatic int gray_ref(input int v);
        if (v == -3 * S / 2) return 0;
        if (v == -S / 2)     return 1;
        if (v == S / 2)      return 3;
        if (v == 3 * S / 2)  return 2;
        return 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_tap(input int addr, input int val);
        tap_we    = 1'b1;
        tap_addr  = 1'(addr);
        tap_wdata = 8'(val);
        tick();
        tap_we = 1'b0;
        m_tap[addr] = val;
    endtask

    // One sample through the pipeline; f_valid rises on e_valid-relative cycle d.
    task automatic run(input string tag, input int smp, input int fb, input int d,
                       input bit wr, input int wa, input int wv);
        int n;
        int exp_est;
        int cap;
        int val;
        bit tout;
        n = 0;
        while (bus.s_ready !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check({tag, ":ready"}, bus.s_ready, 1);
        exp_est = model_est(smp);
        bus.sample  = 16'(smp);
        bus.s_valid = 1'b1;
        tick();
        bus.s_valid = 1'b0;
        check({tag, ":calc_rdy"}, bus.s_ready, 0);
        check({tag, ":calc_ev"}, bus.e_valid, 0);
        if (wr) begin
            tap_we    = 1'b1;
            tap_addr  = 1'(wa);
            tap_wdata = 8'(wv);
        end
        tick();
        tap_we = 1'b0;
        if (wr) m_tap[wa] = wv;
        check({tag, ":ev"}, bus.e_valid, 1);
        check({tag, ":est"}, bus.estimation, exp_est);
        cap  = (d < 1) ? 1 : d;
        tout = (cap > TIMEOUT - 1);
        if (tout) cap = TIMEOUT - 1;
        val  = tout ? 0 : fb;
        for (int c = 0; c <= cap; c++) begin
            bus.f_valid        = (c >= d);
            bus.feedback_value = 16'(fb);
            check({tag, ":wait_sv"}, bus.sym_valid, 0);
            check({tag, ":wait_rdy"}, bus.s_ready, 0);
            tick();
        end
        bus.f_valid = 1'b0;
        m_to = m_to | tout;
        check({tag, ":sv"}, bus.sym_valid, 1);
        check({tag, ":sym"}, bus.sym_out, gray_ref(val));
        check({tag, ":to"}, dec_timeout, m_to);
        check({tag, ":upd_rdy"}, bus.s_ready, 0);
        m_hist[1] = m_hist[0];
        m_hist[0] = val;
        tick();
        check({tag, ":sv_off"}, bus.sym_valid, 0);
        check({tag, ":idle_rdy"}, bus.s_ready, 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ":rdy"}, bus.s_ready, 0);
        check({tag, ":est"}, bus.estimation, 0);
        check({tag, ":ev"}, bus.e_valid, 0);
        check({tag, ":sym"}, bus.sym_out, 0);
        check({tag, ":sv"}, bus.sym_valid, 0);
        check({tag, ":to"}, dec_timeout, 0);
    endtask

    initial begin
        int fbs [7];
        fbs = '{-84, -28, 28, 84, 0, 5, -100};
        rstn = 1'b0;
        tap_we = 1'b0;
        tap_addr = '0;
        tap_wdata = '0;
        bus.sample = '0;
        bus.s_valid = 1'b0;
        bus.feedback_value = '0;
        bus.f_valid = 1'b0;
        m_tap = '{0, 0};
        m_hist = '{0, 0};
        m_to = 1'b0;

        tick();
        tick();
        check_zero("reset");
        rstn = 1'b1;
        check({"release", ":rdy0"}, bus.s_ready, 0);
        tick();
        check({"release", ":rdy1"}, bus.s_ready, 1);

        run("zero_taps", 100, 84, 2, 1'b0, 0, 0);
        write_tap(0, 64);
        run("isi42", 100, 28, 2, 1'b0, 0, 0);

        write_tap(0, 127);
        write_tap(1, 127);
        run("prep_a", 7, -84, 1, 1'b0, 0, 0);
        run("prep_b", -9, -84, 3, 1'b0, 0, 0);
        run("sat_pos", 32700, 84, 1, 1'b0, 0, 0);
        run("prep_c", 0, 84, 2, 1'b0, 0, 0);
        run("sat_neg", -32700, -28, 2, 1'b0, 0, 0);

        run("calc_wr", 500, 28, 2, 1'b1, 0, -50);
        run("after_wr", 500, -84, 2, 1'b0, 0, 0);

        run("late_ok", 321, 84, TIMEOUT - 1, 1'b0, 0, 0);
        run("timeout", 1000, 84, 20, 1'b0, 0, 0);
        run("post_to", -1000, -28, 2, 1'b0, 0, 0);
        run("fv_high", 42, 28, 0, 1'b0, 0, 0);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0)
                write_tap(int'($urandom_range(0, 1)), int'($urandom_range(0, 255)) - 128);
            run("rand", int'($urandom_range(0, 65535)) - 32768,
                fbs[$urandom_range(0, 6)], int'($urandom_range(0, 5)),
                1'($urandom_range(0, 4) == 0), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 255)) - 128);
        end

        // Reset while waiting for a decision that is already being offered.
        bus.sample  = 16'(1234);
        bus.s_valid = 1'b1;
        tick();
        bus.s_valid = 1'b0;
        tick();
        check("mid:ev", bus.e_valid, 1);
        bus.f_valid        = 1'b1;
        bus.feedback_value = 16'(84);
        rstn = 1'b0;
        #1;
        check_zero("mid_rst");
        tick();
        check_zero("mid_hold");
        rstn = 1'b1;
        m_tap = '{0, 0};
        m_hist = '{0, 0};
        m_to = 1'b0;
        check("mid:rel_rdy0", bus.s_ready, 0);
        tick();
        check("mid:rel_rdy1", bus.s_ready, 1);
        check("mid:rel_sv", bus.sym_valid, 0);
        check("mid:rel_ev", bus.e_valid, 0);
        tick();
        check("mid:rel_sv2", bus.sym_valid, 0);
        bus.f_valid = 1'b0;
        run("post_rst", 777, 28, 2, 1'b0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
